// File: rtl/mem_block_transfer_buffer_if.sv
// Memory-side bus of the block transfer buffer: a command channel
// (req/rw/add with ready), a write-data channel (wdata/wvalid/wready)
// and a read-data channel (rdata/rvalid). The buffer is the master and
// the external memory is the slave.
interface mem_block_transfer_buffer_if #(
  parameter int BW_ADDR = 24
);
  logic               mem_req;
  logic               mem_rw;
  logic [BW_ADDR-1:0] mem_add;
  logic               mem_ready;
  logic [31:0]        mem_wdata;
  logic               mem_wvalid;
  logic               mem_wready;
  logic [31:0]        mem_rdata;
  logic               mem_rvalid;

  modport master (
    output mem_req, mem_rw, mem_add, mem_wdata, mem_wvalid,
    input  mem_ready, mem_wready, mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_req, mem_rw, mem_add, mem_wdata, mem_wvalid,
    output mem_ready, mem_wready, mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/mem_block_transfer_buffer.sv
// Block transfer buffer between the lease cache memory-controller port
// and external memory. One block-deep first-word-fall-through FIFO holds
// either writeback data (filled by the cache, drained to memory) or fill
// data (filled by memory, drained by the cache). A single request is in
// flight at a time.
// Optional build macro MEM_BUFFER_STATS_EN adds saturating counters of
// completed read and write commands (stat_reads_o / stat_writes_o).
module mem_block_transfer_buffer #(
  parameter int BW_ADDR     = 24,
  parameter int BW_BLOCK    = 4,
  parameter int BLOCK_WORDS = 2 ** BW_BLOCK
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               req_i,
  input  logic               req_block_i,
  input  logic               rw_i,
  input  logic [BW_ADDR-1:0] add_i,
  output logic               ready_req_o,
  input  logic               write_i,
  input  logic [31:0]        data_i,
  output logic               ready_write_o,
  input  logic               read_i,
  output logic [31:0]        data_o,
  output logic               ready_read_o,
  mem_block_transfer_buffer_if.master mem
`ifdef MEM_BUFFER_STATS_EN
  ,
  output logic [31:0]        stat_reads_o,
  output logic [31:0]        stat_writes_o
`endif
);

  localparam int CW = BW_BLOCK + 1;

  typedef enum logic [2:0] {IDLE, WFILL, ISSUE, WDRAIN, READ} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       len_q, len_d;
  logic [CW-1:0]       pushed_q, pushed_d;
  logic [CW-1:0]       popped_q, popped_d;
  logic [CW-1:0]       count_q, count_d;
  logic [BW_BLOCK-1:0] wrPtr_q, wrPtr_d;
  logic [BW_BLOCK-1:0] rdPtr_q, rdPtr_d;
  logic                rw_q, rw_d;
  logic [BW_ADDR-1:0]  addr_q, addr_d;
  logic [31:0]         fifoMem_q [BLOCK_WORDS];

  logic        fifoEmpty;
  logic        canWrite;
  logic        canRead;
  logic        wordOut;
  logic        pushEn;
  logic        popEn;
  logic [31:0] pushData;
  logic [31:0] headWord;

  assign fifoEmpty = (count_q == '0);
  assign headWord  = fifoEmpty ? 32'd0 : fifoMem_q[rdPtr_q];

  // Handshake decode, FIFO bookkeeping and next-state selection
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    pushed_d = pushed_q;
    popped_d = popped_q;
    count_d  = count_q;
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;

    canWrite = (state_q == WFILL) && (pushed_q < len_q);
    canRead  = (state_q == READ) && !fifoEmpty;
    wordOut  = (state_q == WDRAIN) && !fifoEmpty;
    pushEn   = (canWrite && write_i) ||
               ((state_q == READ) && mem.mem_rvalid && (pushed_q < len_q));
    popEn    = (wordOut && mem.mem_wready) || (canRead && read_i);
    pushData = (state_q == READ) ? mem.mem_rdata : data_i;

    ready_req_o    = (state_q == IDLE);
    ready_write_o  = canWrite;
    ready_read_o   = canRead;
    data_o         = headWord;
    mem.mem_req    = (state_q == ISSUE);
    mem.mem_rw     = rw_q;
    mem.mem_add    = addr_q;
    mem.mem_wvalid = wordOut;
    mem.mem_wdata  = headWord;

    if (pushEn) begin
      pushed_d = pushed_q + CW'(1);
      wrPtr_d  = wrPtr_q + BW_BLOCK'(1);
    end
    if (popEn) begin
      popped_d = popped_q + CW'(1);
      rdPtr_d  = rdPtr_q + BW_BLOCK'(1);
    end
    if (pushEn && !popEn) begin
      count_d = count_q + CW'(1);
    end else if (!pushEn && popEn) begin
      count_d = count_q - CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (req_i) begin
          len_d    = req_block_i ? CW'(BLOCK_WORDS) : CW'(1);
          rw_d     = rw_i;
          addr_d   = req_block_i ? (add_i & ~BW_ADDR'(BLOCK_WORDS - 1)) : add_i;
          pushed_d = '0;
          popped_d = '0;
          state_d  = rw_i ? WFILL : ISSUE;
        end
      end
      WFILL: begin
        if (pushEn && (pushed_q + CW'(1) == len_q)) state_d = ISSUE;
      end
      ISSUE: begin
        if (mem.mem_ready) state_d = rw_q ? WDRAIN : READ;
      end
      WDRAIN, READ: begin
        if (popEn && (popped_q + CW'(1) == len_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and pointer registers, all cleared by synchronous reset
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      len_q    <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      pushed_q <= '0;
      popped_q <= '0;
      count_q  <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      pushed_q <= pushed_d;
      popped_q <= popped_d;
      count_q  <= count_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
    end
  end

  // FIFO storage; contents are invalidated by the count, not cleared
  always_ff @(posedge clock_i) begin
    if (pushEn && !reset_i) fifoMem_q[wrPtr_q] <= pushData;
  end

`ifdef MEM_BUFFER_STATS_EN
  logic [31:0] statReads_q;
  logic [31:0] statWrites_q;
  logic        issueDone;

  assign issueDone     = (state_q == ISSUE) && mem.mem_ready;
  assign stat_reads_o  = statReads_q;
  assign stat_writes_o = statWrites_q;

  // Count completed command handshakes, saturating at all-ones
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      statReads_q  <= '0;
      statWrites_q <= '0;
    end else if (issueDone) begin
      if (!rw_q && (statReads_q != '1)) statReads_q <= statReads_q + 32'd1;
      if (rw_q && (statWrites_q != '1)) statWrites_q <= statWrites_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_block_transfer_buffer.sv
// Self-checking bench for mem_block_transfer_buffer. Expected data words
// are queued when stimulus is driven and compared when the DUT presents
// them to memory or to the cache. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_mem_block_transfer_buffer;

  logic        clock_i;
  logic        reset_i;
  logic        req_i;
  logic        req_block_i;
  logic        rw_i;
  logic [23:0] add_i;
  logic        ready_req_o;
  logic        write_i;
  logic [31:0] data_i;
  logic        ready_write_o;
  logic        read_i;
  logic [31:0] data_o;
  logic        ready_read_o;
`ifdef MEM_BUFFER_STATS_EN
  logic [31:0] stat_reads_o;
  logic [31:0] stat_writes_o;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] sbq[$];
  logic [31:0] expWord;

  mem_block_transfer_buffer_if #(.BW_ADDR(24)) mem ();

  mem_block_transfer_buffer #(.BW_ADDR(24), .BW_BLOCK(4), .BLOCK_WORDS(16)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .req_i        (req_i),
    .req_block_i  (req_block_i),
    .rw_i         (rw_i),
    .add_i        (add_i),
    .ready_req_o  (ready_req_o),
    .write_i      (write_i),
    .data_i       (data_i),
    .ready_write_o(ready_write_o),
    .read_i       (read_i),
    .data_o       (data_o),
    .ready_read_o (ready_read_o),
    .mem          (mem)
`ifdef MEM_BUFFER_STATS_EN
    ,
    .stat_reads_o (stat_reads_o),
    .stat_writes_o(stat_writes_o)
`endif
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
    checks++; if (ready_req_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_req: got %b expected 1", ready_req_o); end
    checks++; if (ready_write_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_write: got %b expected 0", ready_write_o); end
    checks++; if (ready_read_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_read: got %b expected 0", ready_read_o); end
    checks++; if (mem.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem.mem_req); end
    checks++; if (mem.mem_wvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_wvalid: got %b expected 0", mem.mem_wvalid); end
    checks++; if (data_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_data_o: got %h expected 0", data_o); end
  endtask

  task automatic run_single_read(input logic [23:0] a, input logic [31:0] w);
    req_i = 1'b1; rw_i = 1'b0; req_block_i = 1'b0; add_i = a;
    @(negedge clock_i);
    req_i = 1'b0;
    checks++; if (mem.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL sread_mem_req: got %b expected 1", mem.mem_req); end
    checks++; if (mem.mem_add !== a) begin errors++; $display("[TB] FAIL sread_mem_add: got %h expected %h", mem.mem_add, a); end
    checks++; if (mem.mem_rw !== 1'b0) begin errors++; $display("[TB] FAIL sread_mem_rw: got %b expected 0", mem.mem_rw); end
    mem.mem_ready = 1'b1;
    @(negedge clock_i);
    mem.mem_ready = 1'b0;
    mem.mem_rvalid = 1'b1; mem.mem_rdata = w; sbq.push_back(w);
    @(negedge clock_i);
    mem.mem_rvalid = 1'b0;
    checks++; if (ready_read_o !== 1'b1) begin errors++; $display("[TB] FAIL sread_ready_read: got %b expected 1", ready_read_o); end
    expWord = sbq.pop_front();
    checks++; if (data_o !== expWord) begin errors++; $display("[TB] FAIL sread_data: got %h expected %h", data_o, expWord); end
    read_i = 1'b1;
    @(negedge clock_i);
    read_i = 1'b0;
    checks++; if (ready_req_o !== 1'b1) begin errors++; $display("[TB] FAIL sread_idle: got %b expected 1", ready_req_o); end
    checks++; if (ready_read_o !== 1'b0) begin errors++; $display("[TB] FAIL sread_ready_read_end: got %b expected 0", ready_read_o); end
  endtask

  task automatic run_single_write(input logic [23:0] a, input logic [31:0] w);
    req_i = 1'b1; rw_i = 1'b1; req_block_i = 1'b0; add_i = a;
    @(negedge clock_i);
    req_i = 1'b0;
    checks++; if (ready_write_o !== 1'b1) begin errors++; $display("[TB] FAIL swrite_ready_write: got %b expected 1", ready_write_o); end
    write_i = 1'b1; data_i = w; sbq.push_back(w);
    @(negedge clock_i);
    write_i = 1'b0;
    checks++; if (mem.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL swrite_mem_req: got %b expected 1", mem.mem_req); end
    checks++; if (mem.mem_add !== a) begin errors++; $display("[TB] FAIL swrite_mem_add: got %h expected %h", mem.mem_add, a); end
    mem.mem_ready = 1'b1;
    @(negedge clock_i);
    mem.mem_ready = 1'b0;
    expWord = sbq.pop_front();
    checks++; if (mem.mem_wvalid !== 1'b1 || mem.mem_wdata !== expWord) begin errors++; $display("[TB] FAIL swrite_wdata: got v=%b %h expected v=1 %h", mem.mem_wvalid, mem.mem_wdata, expWord); end
    mem.mem_wready = 1'b1;
    @(negedge clock_i);
    mem.mem_wready = 1'b0;
    checks++; if (ready_req_o !== 1'b1) begin errors++; $display("[TB] FAIL swrite_idle: got %b expected 1", ready_req_o); end
  endtask

  task automatic test_single_read();
    run_single_read(24'h000123, 32'hDEADBEEF);
  endtask

  task automatic test_block_write();
    int pops;
    req_i = 1'b1; rw_i = 1'b1; req_block_i = 1'b1; add_i = 24'h00045A;
    @(negedge clock_i);
    req_i = 1'b0;
    checks++; if (ready_write_o !== 1'b1) begin errors++; $display("[TB] FAIL bwrite_ready_write: got %b expected 1", ready_write_o); end
    for (int i = 0; i < 16; i++) begin
      write_i = 1'b1; data_i = 32'(i); sbq.push_back(32'(i));
      @(negedge clock_i);
    end
    // a further write strobe after the 16th push must be ignored
    data_i = 32'hBAD00BAD;
    checks++; if (ready_write_o !== 1'b0) begin errors++; $display("[TB] FAIL bwrite_ready_write_drop: got %b expected 0", ready_write_o); end
    checks++; if (mem.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL bwrite_mem_req: got %b expected 1", mem.mem_req); end
    checks++; if (mem.mem_add !== 24'h000450) begin errors++; $display("[TB] FAIL bwrite_mem_add: got %h expected 000450", mem.mem_add); end
    checks++; if (mem.mem_rw !== 1'b1) begin errors++; $display("[TB] FAIL bwrite_mem_rw: got %b expected 1", mem.mem_rw); end
    mem.mem_ready = 1'b1;
    @(negedge clock_i);
    write_i = 1'b0; mem.mem_ready = 1'b0;
    // a request during the drain must be ignored
    req_i = 1'b1; rw_i = 1'b0; req_block_i = 1'b0;
    @(negedge clock_i);
    req_i = 1'b0;
    checks++; if (ready_req_o !== 1'b0 || mem.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL bwrite_illegal_req: got rdy=%b req=%b expected 0 0", ready_req_o, mem.mem_req); end
    checks++; if (mem.mem_wvalid !== 1'b1 || mem.mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL bwrite_head: got v=%b %h expected v=1 0", mem.mem_wvalid, mem.mem_wdata); end
    pops = 0;
    for (int c = 0; c < 200 && pops < 16; c++) begin
      mem.mem_wready = c[0];
      if (mem.mem_wvalid && mem.mem_wready) begin
        expWord = (sbq.size() > 0) ? sbq.pop_front() : 32'hFFFFFFFF;
        checks++; if (mem.mem_wdata !== expWord) begin errors++; $display("[TB] FAIL bwrite_wdata: got %h expected %h", mem.mem_wdata, expWord); end
        pops++;
      end
      @(negedge clock_i);
    end
    mem.mem_wready = 1'b0;
    checks++; if (pops != 16) begin errors++; $display("[TB] FAIL bwrite_drain_count: got %0d expected 16", pops); end
    checks++; if (ready_req_o !== 1'b1 || mem.mem_wvalid !== 1'b0) begin errors++; $display("[TB] FAIL bwrite_idle: got rdy=%b wv=%b expected 1 0", ready_req_o, mem.mem_wvalid); end
    sbq.delete();
  endtask

  task automatic test_back_to_back_read();
    int pops;
    int sent;
    req_i = 1'b1; rw_i = 1'b0; req_block_i = 1'b1; add_i = 24'hABCDEF;
    @(negedge clock_i);
    req_i = 1'b0;
    checks++; if (mem.mem_req !== 1'b1 || mem.mem_add !== 24'hABCDE0) begin errors++; $display("[TB] FAIL bread_cmd: got req=%b %h expected 1 abcde0", mem.mem_req, mem.mem_add); end
    mem.mem_ready = 1'b1;
    @(negedge clock_i);
    mem.mem_ready = 1'b0;
    // pop while empty must be ignored
    read_i = 1'b1;
    @(negedge clock_i);
    read_i = 1'b0;
    checks++; if (ready_read_o !== 1'b0 || ready_req_o !== 1'b0) begin errors++; $display("[TB] FAIL bread_empty_pop: got rr=%b rq=%b expected 0 0", ready_read_o, ready_req_o); end
    pops = 0; sent = 0;
    for (int c = 0; c < 100 && pops < 16; c++) begin
      if (ready_read_o) begin
        expWord = (sbq.size() > 0) ? sbq.pop_front() : 32'hFFFFFFFF;
        checks++; if (data_o !== expWord) begin errors++; $display("[TB] FAIL bread_data: got %h expected %h", data_o, expWord); end
        read_i = 1'b1; pops++;
      end else begin
        read_i = 1'b0;
      end
      mem.mem_rvalid = 1'b1;
      if (sent < 16) begin
        mem.mem_rdata = 32'hA5000000 + 32'(sent); sbq.push_back(mem.mem_rdata); sent++;
      end else begin
        mem.mem_rdata = 32'hBAD0BAD0;
      end
      @(negedge clock_i);
    end
    mem.mem_rvalid = 1'b0; read_i = 1'b0;
    checks++; if (pops != 16) begin errors++; $display("[TB] FAIL bread_pop_count: got %0d expected 16", pops); end
    checks++; if (ready_req_o !== 1'b1 || ready_read_o !== 1'b0) begin errors++; $display("[TB] FAIL bread_idle: got rq=%b rr=%b expected 1 0", ready_req_o, ready_read_o); end
    checks++; if (data_o !== 32'd0) begin errors++; $display("[TB] FAIL bread_fifo_empty: got %h expected 0", data_o); end
    sbq.delete();
  endtask

  task automatic test_reset_mid_read();
    req_i = 1'b1; rw_i = 1'b0; req_block_i = 1'b1; add_i = 24'h000100;
    @(negedge clock_i);
    req_i = 1'b0; mem.mem_ready = 1'b1;
    @(negedge clock_i);
    mem.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'hC0DE0000 + 32'(i);
      @(negedge clock_i);
    end
    checks++; if (ready_read_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_ready_read: got %b expected 1", ready_read_o); end
    reset_i = 1'b1; mem.mem_rdata = 32'hDEAD0001;
    @(negedge clock_i);
    reset_i = 1'b0; mem.mem_rdata = 32'hDEAD0002;
    checks++; if (ready_req_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready_req: got %b expected 1", ready_req_o); end
    checks++; if (ready_read_o !== 1'b0 || mem.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_outputs: got rr=%b req=%b expected 0 0", ready_read_o, mem.mem_req); end
    @(negedge clock_i);
    mem.mem_rvalid = 1'b0;
    checks++; if (data_o !== 32'd0) begin errors++; $display("[TB] FAIL rst_late_data: got %h expected 0", data_o); end
    run_single_read(24'h000777, 32'h12345678);
  endtask

`ifdef MEM_BUFFER_STATS_EN
  task automatic test_stats();
    reset_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;
    checks++; if (stat_reads_o !== 32'd0 || stat_writes_o !== 32'd0) begin errors++; $display("[TB] FAIL stats_reset: got %0d %0d expected 0 0", stat_reads_o, stat_writes_o); end
    for (int i = 0; i < 3; i++) run_single_read(24'h000200 + 24'(i), 32'h55550000 + 32'(i));
    for (int i = 0; i < 2; i++) run_single_write(24'h000300 + 24'(i), 32'h66660000 + 32'(i));
    checks++; if (stat_reads_o !== 32'd3) begin errors++; $display("[TB] FAIL stats_reads: got %0d expected 3", stat_reads_o); end
    checks++; if (stat_writes_o !== 32'd2) begin errors++; $display("[TB] FAIL stats_writes: got %0d expected 2", stat_writes_o); end
    force dut.statReads_q = 32'hFFFFFFFF;
    force dut.statWrites_q = 32'hFFFFFFFF;
    #1;
    release dut.statReads_q;
    release dut.statWrites_q;
    run_single_read(24'h000400, 32'h77770000);
    run_single_write(24'h000500, 32'h88880000);
    checks++; if (stat_reads_o !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL stats_reads_sat: got %h expected ffffffff", stat_reads_o); end
    checks++; if (stat_writes_o !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL stats_writes_sat: got %h expected ffffffff", stat_writes_o); end
  endtask
`endif

  initial begin
    reset_i = 1'b1; req_i = 1'b0; req_block_i = 1'b0; rw_i = 1'b0; add_i = '0;
    write_i = 1'b0; data_i = '0; read_i = 1'b0;
    mem.mem_ready = 1'b0; mem.mem_wready = 1'b0; mem.mem_rdata = '0; mem.mem_rvalid = 1'b0;
    @(negedge clock_i);
    $display("[TB] starting");
    test_reset();
    test_single_read();
    test_block_write();
    test_back_to_back_read();
    test_reset_mid_read();
`ifdef MEM_BUFFER_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
